// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - issue, operand and writeback signal bundle for operand_fetch
interface operand_fetch_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       readnum_a;
  logic [2:0]       readnum_b;
  logic [1:0]       shift;
  logic             asel;
  logic             bsel;
  logic [WIDTH-1:0] sximm;
  logic [1:0]       aluop_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [1:0]       ALUop;
  logic             wb_en;
  logic [2:0]       wb_num;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output in_valid, readnum_a, readnum_b, shift, asel, bsel, sximm, aluop_in,
    output out_ready, wb_en, wb_num, wb_data,
    input  in_ready, out_valid, Ain, Bin, ALUop
  );

  modport slave (
    input  in_valid, readnum_a, readnum_b, shift, asel, bsel, sximm, aluop_in,
    input  out_ready, wb_en, wb_num, wb_data,
    output in_ready, out_valid, Ain, Bin, ALUop
  );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file read, B shifter and one-deep operand pipeline register
module operand_fetch #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave bus
);

  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] b_shifted;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             out_valid_q;
  logic [WIDTH-1:0] ain_q;
  logic [WIDTH-1:0] bin_q;
  logic [1:0]       aluop_q;
  logic             issue;

  // The stage can take a new set whenever the held set is absent or leaving now.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign issue         = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.ALUop     = aluop_q;

  // Combinational reads; a same-cycle writeback to the read index is forwarded.
  always_comb begin
    rd_a = regs[bus.readnum_a];
    rd_b = regs[bus.readnum_b];
    if (bus.wb_en && (bus.wb_num == bus.readnum_a)) rd_a = bus.wb_data;
    if (bus.wb_en && (bus.wb_num == bus.readnum_b)) rd_b = bus.wb_data;
  end

  // Single-bit shifter on the register path of B only; the immediate bypasses it.
  always_comb begin
    b_shifted = rd_b;
    case (bus.shift)
      2'b01:   b_shifted = {rd_b[WIDTH-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, rd_b[WIDTH-1:1]};
      2'b11:   b_shifted = {rd_b[WIDTH-1], rd_b[WIDTH-1:1]};
      default: b_shifted = rd_b;
    endcase
    a_next = bus.asel ? '0 : rd_a;
    b_next = bus.bsel ? bus.sximm : b_shifted;
  end

  // Register file: writeback is independent of the issue/consume handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (bus.wb_en) begin
      regs[bus.wb_num] <= bus.wb_data;
    end
  end

  // Operand register: load on issue, drop valid on a consume with no refill, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ain_q       <= '0;
      bin_q       <= '0;
      aluop_q     <= 2'b00;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      ain_q       <= a_next;
      bin_q       <= b_next;
      aluop_q     <= bus.aluop_in;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];
  logic [W-1:0] model [8];

  operand_fetch_if #(.WIDTH(W)) bus ();

  operand_fetch #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rd(input logic [2:0] idx);
    if (bus.wb_en && bus.wb_num == idx) return bus.wb_data;
    return model[idx];
  endfunction

  function automatic logic [W-1:0] shf(input logic [W-1:0] v, input logic [1:0] sh);
    case (sh)
      2'b01:   return {v[W-2:0], 1'b0};
      2'b10:   return {1'b0, v[W-1:1]};
      2'b11:   return {v[W-1], v[W-1:1]};
      default: return v;
    endcase
  endfunction

  // Reference register file.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) model[i] <= '0;
    end else if (bus.wb_en) begin
      model[bus.wb_num] <= bus.wb_data;
    end
  end

  // Scoreboard: pop and compare on consume, push predicted set on accepted issue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_ain", 32'(bus.Ain), 32'(e.a));
          check("sb_bin", 32'(bus.Bin), 32'(e.b));
          check("sb_aluop", 32'(bus.ALUop), 32'(e.op));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.a  = bus.asel ? '0 : rd(bus.readnum_a);
        e.b  = bus.bsel ? bus.sximm : shf(rd(bus.readnum_b), bus.shift);
        e.op = bus.aluop_in;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
  endtask

  task automatic set_wb(input logic [2:0] n, input logic [W-1:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_num  = n;
    bus.wb_data = d;
  endtask

  task automatic set_issue(input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] sh,
                           input logic as, input logic bs, input logic [W-1:0] imm,
                           input logic [1:0] op);
    bus.in_valid  = 1'b1;
    bus.readnum_a = ra;
    bus.readnum_b = rb;
    bus.shift     = sh;
    bus.asel      = as;
    bus.bsel      = bs;
    bus.sximm     = imm;
    bus.aluop_in  = op;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.out_ready = 1'b1;
    bus.wb_num    = '0;
    bus.wb_data   = '0;
    set_issue(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, '0, 2'b00);
    idle();

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_ain", 32'(bus.Ain), 32'd0);
    check("rst_bin", 32'(bus.Bin), 32'd0);
    check("rst_aluop", 32'(bus.ALUop), 32'd0);
    rst_n = 1'b1;
    tick();

    // Arithmetic right shift of R3 with A forced to zero
    set_wb(3'd3, 16'h8001);
    tick();
    idle();
    set_issue(3'd0, 3'd3, 2'b11, 1'b1, 1'b0, '0, 2'b01);
    tick();
    idle();
    check("asr_valid", 32'(bus.out_valid), 32'd1);
    check("asr_ain", 32'(bus.Ain), 32'h0000);
    check("asr_bin", 32'(bus.Bin), 32'hC000);
    tick();

    // Write bypass on the A read
    set_wb(3'd2, 16'h1234);
    set_issue(3'd2, 3'd0, 2'b00, 1'b0, 1'b1, 16'h0055, 2'b10);
    tick();
    idle();
    check("bypass_ain", 32'(bus.Ain), 32'h1234);
    check("bypass_bin", 32'(bus.Bin), 32'h0055);
    tick();

    // Stall while R1 is rewritten; a second issue waits and lands with the consume
    set_wb(3'd1, 16'h1111);
    tick();
    idle();
    bus.out_ready = 1'b0;
    set_issue(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, '0, 2'b01);
    tick();
    set_issue(3'd1, 3'd1, 2'b01, 1'b0, 1'b0, '0, 2'b10);
    for (int i = 0; i < 3; i++) begin
      set_wb(3'd1, 16'hAAA0 + 16'(i));
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_ain", 32'(bus.Ain), 32'h1111);
      check("stall_bin", 32'(bus.Bin), 32'h1111);
      check("stall_aluop", 32'(bus.ALUop), 32'd1);
    end
    bus.wb_en = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("refill_valid", 32'(bus.out_valid), 32'd1);
    check("refill_ain", 32'(bus.Ain), 32'hAAA2);
    check("refill_bin", 32'(bus.Bin), 32'h5544);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Random register contents, then back-to-back issues with concurrent writebacks
    for (int i = 0; i < 8; i++) begin
      set_wb(3'(i), 16'($urandom));
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      set_issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                2'($urandom_range(0, 3)));
      set_wb(3'($urandom_range(0, 7)), 16'($urandom));
      tick();
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
    end
    idle();
    tick();
    check("b2b_drain", 32'(bus.out_valid), 32'd0);

    // Shift boundaries on an all-ones register and an unshifted immediate
    set_wb(3'd5, 16'hFFFF);
    tick();
    idle();
    set_issue(3'd0, 3'd5, 2'b01, 1'b0, 1'b0, '0, 2'b00);
    tick();
    check("shl_bin", 32'(bus.Bin), 32'hFFFE);
    set_issue(3'd0, 3'd5, 2'b10, 1'b0, 1'b0, '0, 2'b00);
    tick();
    check("lsr_bin", 32'(bus.Bin), 32'h7FFF);
    set_issue(3'd0, 3'd5, 2'b01, 1'b0, 1'b1, 16'hFFF0, 2'b00);
    tick();
    check("imm_bin", 32'(bus.Bin), 32'hFFF0);
    idle();
    tick();

    // Reset asserted mid-stall
    bus.out_ready = 1'b0;
    set_issue(3'd5, 3'd5, 2'b00, 1'b0, 1'b0, '0, 2'b11);
    tick();
    idle();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_aluop", 32'(bus.ALUop), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_ain", 32'(bus.Ain), 32'd0);
    check("arst_bin", 32'(bus.Bin), 32'd0);
    check("arst_aluop", 32'(bus.ALUop), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_issue(3'(i), 3'(i), 2'b00, 1'b0, 1'b0, '0, 2'b00);
      tick();
      check("cleared_ain", 32'(bus.Ain), 32'd0);
      check("cleared_bin", 32'(bus.Bin), 32'd0);
    end
    idle();
    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001: The block SHALL have parameter WIDTH, default 16, giving the datapath word width; all data ports below are WIDTH bits.
REQ-002: The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003: The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004: The block SHALL have port in_valid, input, 1, an issue request is present.
REQ-005: The block SHALL have port in_ready, output, 1, the stage accepts an issue this cycle.
REQ-006: The block SHALL have ports readnum_a and readnum_b, input, 3 each, the source register indices for A and B.
REQ-007: The block SHALL have port shift, input, 2: 00 none, 01 left by 1 (zero fill), 10 logical right by 1, 11 arithmetic right by 1.
REQ-008: The block SHALL have port asel, input, 1; 1 forces the A operand to zero.
REQ-009: The block SHALL have port bsel, input, 1; 1 selects the immediate for the B operand.
REQ-010: The block SHALL have port sximm, input, WIDTH, the sign-extended immediate.
REQ-011: The block SHALL have port aluop_in, input, 2, the ALU operation to forward.
REQ-012: The block SHALL have port out_valid, output, 1, a registered operand set is presented.
REQ-013: The block SHALL have port out_ready, input, 1, the ALU stage consumes this cycle.
REQ-014: The block SHALL have ports Ain and Bin, output, WIDTH each, the registered operands.
REQ-015: The block SHALL have port ALUop, output, 2, the registered operation.
REQ-016: The block SHALL have port wb_en, input, 1, writeback strobe.
REQ-017: The block SHALL have port wb_num, input, 3, the writeback register index.
REQ-018: The block SHALL have port wb_data, input, WIDTH, the writeback value.

Function
REQ-019: The block SHALL contain an 8-entry x WIDTH register file written at the clock edge when wb_en=1 at index wb_num.
REQ-020: Register reads SHALL be combinational with write bypass: if wb_en=1 and wb_num equals the read index, the read returns wb_data instead of the stored value.
REQ-021: The A operand SHALL be zero when asel=1, otherwise the read value at readnum_a.
REQ-022: The B operand SHALL be sximm when bsel=1, otherwise the read value at readnum_b shifted per shift; the immediate SHALL never be shifted.
REQ-023: Shifts SHALL be by exactly one bit and keep WIDTH bits: left discards the MSB, logical right fills 0, arithmetic right replicates the MSB.
REQ-024: in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-025: When in_valid and in_ready are both 1, the block SHALL register Ain, Bin and ALUop from the current inputs and set out_valid=1 at the next edge; latency from issue to out_valid is one cycle.
REQ-026: When out_valid=1 and out_ready=1 with no new issue, the block SHALL clear out_valid at the next edge.
REQ-027: While out_valid=1 and out_ready=0, Ain, Bin and ALUop SHALL hold stable, and in_ready SHALL be 0.
REQ-028: Captured operands SHALL be snapshots; a writeback after capture SHALL NOT alter a held output.
REQ-029: Simultaneous consume and issue SHALL keep out_valid=1 and load the new set in the same cycle, with no bubble.
REQ-030: Writeback SHALL proceed every cycle regardless of the handshake state.

Reset
REQ-031: While rst_n=0, the block SHALL asynchronously clear all 8 registers, out_valid, Ain, Bin and ALUop to 0.
REQ-032: Reset asserted mid-stall SHALL discard the held operand set; after release, in_ready=1.

Verification
REQ-033: Reset, then write R3=0x8001 and issue readnum_b=3, shift=11, bsel=0, asel=1 -> next cycle out_valid=1, Ain=0x0000, Bin=0xC000.
REQ-034: Same cycle wb_en=1, wb_num=2, wb_data=0x1234 with an issue of readnum_a=2 -> Ain=0x1234 (bypass).
REQ-035: Issue with out_ready=0 for 3 cycles while R1 is rewritten -> in_ready=0 and outputs unchanged until out_ready=1.
REQ-036: Back-to-back issues with out_ready=1 every cycle -> out_valid stays 1 and each operand set appears exactly one cycle after its issue.
REQ-037: Issue with R5=0xFFFF, shift=01 -> Bin=0xFFFE; issue with shift=10 -> Bin=0x7FFF; issue with bsel=1, sximm=0xFFF0, shift=01 -> Bin=0xFFF0.
REQ-038: Assert rst_n=0 while stalled with out_valid=1 -> out_valid, Ain, Bin and ALUop are 0 immediately, and all registers read 0 after release.
